// File: rtl/cpu_phase_pkg.sv
// rtl/cpu_phase_pkg.sv - state and phase encodings shared by cpu_phase_ctrl, the decoder and the bench
package cpu_phase_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam logic [1:0] PH_FT = 2'd0;
    localparam logic [1:0] PH_DC = 2'd1;
    localparam logic [1:0] PH_EX = 2'd2;
    localparam logic [1:0] PH_WB = 2'd3;

    // Phase order wraps WB -> FT through the natural 2-bit overflow.
    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return ph + 2'd1;
    endfunction

endpackage

// File: rtl/cpu_instr_counter.sv
// rtl/cpu_instr_counter.sv - retired-instruction counter, wraps modulo 2^CNT_W, cleared only by clear_i
module cpu_instr_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_phase_ctrl.sv
// rtl/cpu_phase_ctrl.sv - run/stop/step sequencer issuing one-hot FT/DC/EX/WB enables for cpu15
// Optional retired-instruction counter built only with CPU_PHASE_INSTR_CNT_EN defined.
module cpu_phase_ctrl
    import cpu_phase_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             STEP,
    input  logic             HALT_REQ,
    input  logic             STALL,
    output logic             PHASE_FT,
    output logic             PHASE_DC,
    output logic             PHASE_EX,
    output logic             PHASE_WB,
    output logic             RUNNING,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_CNT
);

    logic [1:0] state_q, state_d;
    logic [1:0] ph_q, ph_d;
    logic       stop_pend_q, stop_pend_d;
    logic       halt_pend_q, halt_pend_d;

    logic active;
    logic strobe;
    logic wb_edge;

    assign active  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign strobe  = active && !STALL;
    assign wb_edge = strobe && (ph_q == PH_WB);

    assign PHASE_FT = strobe && (ph_q == PH_FT);
    assign PHASE_DC = strobe && (ph_q == PH_DC);
    assign PHASE_EX = strobe && (ph_q == PH_EX);
    assign PHASE_WB = wb_edge;
    assign RUNNING  = active;
    assign HALTED   = (state_q == ST_HALTED);

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        stop_pend_d = stop_pend_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (STEP) begin
                    state_d = ST_STEP;
                end else if (START) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (state_q == ST_RUN && STOP) begin
                    stop_pend_d = 1'b1;
                end
                if (PHASE_EX && HALT_REQ) begin
                    halt_pend_d = 1'b1;
                end
                if (strobe) begin
                    ph_d = next_phase(ph_q);
                end
                // Instruction boundary; a STOP arriving on the WB cycle itself still counts.
                if (wb_edge) begin
                    stop_pend_d = 1'b0;
                    halt_pend_d = 1'b0;
                    if (halt_pend_q) begin
                        state_d = ST_HALTED;
                    end else if (state_q == ST_STEP) begin
                        state_d = ST_IDLE;
                    end else if (stop_pend_q || STOP) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ph_q        <= PH_FT;
            stop_pend_q <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            stop_pend_q <= stop_pend_d;
            halt_pend_q <= halt_pend_d;
        end
    end

`ifdef CPU_PHASE_INSTR_CNT_EN
    cpu_instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk_i   (CLK),
        .clear_i (RST),
        .inc_i   (wb_edge),
        .count_o (INSTR_CNT)
    );
`else
    assign INSTR_CNT = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// tb/tb_cpu_phase_ctrl.sv - directed vector table plus randomized run against a behavioural model
module tb_cpu_phase_ctrl;

    localparam int CNT_W = 32;

    logic             CLK;
    logic             RST, START, STOP, STEP, HALT_REQ, STALL;
    logic             PHASE_FT, PHASE_DC, PHASE_EX, PHASE_WB;
    logic             RUNNING, HALTED;
    logic [CNT_W-1:0] INSTR_CNT;

    cpu_phase_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .STOP      (STOP),
        .STEP      (STEP),
        .HALT_REQ  (HALT_REQ),
        .STALL     (STALL),
        .PHASE_FT  (PHASE_FT),
        .PHASE_DC  (PHASE_DC),
        .PHASE_EX  (PHASE_EX),
        .PHASE_WB  (PHASE_WB),
        .RUNNING   (RUNNING),
        .HALTED    (HALTED),
        .INSTR_CNT (INSTR_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit       chk;
        bit       rst, start, stop, step, halt_req, stall;
        bit [3:0] ph;   // {FT,DC,EX,WB}
        bit       run, hal;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: a machine that is either idle, executing (possibly a single
    // instruction), or halted; the position inside the instruction is an integer 0..3.
    bit          m_valid = 0;
    bit          m_busy, m_single, m_halted, m_want_stop, m_want_halt;
    int          m_pos;
    logic [31:0] m_retired;

    function automatic void add(bit chk, bit r, bit st, bit sp, bit se, bit h, bit sl,
                                bit [3:0] ph, bit run, bit hal);
        vec_t v;
        v.chk = chk; v.rst = r; v.start = st; v.stop = sp; v.step = se;
        v.halt_req = h; v.stall = sl; v.ph = ph; v.run = run; v.hal = hal;
        vecs.push_back(v);
    endfunction

    task automatic model_edge();
        if (RST) begin
            m_valid = 1; m_busy = 0; m_single = 0; m_halted = 0;
            m_want_stop = 0; m_want_halt = 0; m_pos = 0; m_retired = 0;
        end else if (m_valid) begin
            if (m_halted) begin
                if (START) begin m_halted = 0; m_busy = 1; m_single = 0; end
            end else if (!m_busy) begin
                if (STOP) begin end
                else if (STEP) begin m_busy = 1; m_single = 1; end
                else if (START) begin m_busy = 1; m_single = 0; end
            end else begin
                if (!m_single && STOP) m_want_stop = 1;
                if (!STALL) begin
                    if (m_pos == 2 && HALT_REQ) m_want_halt = 1;
                    if (m_pos == 3) begin
                        m_retired = m_retired + 1;
                        if (m_want_halt) begin m_busy = 0; m_halted = 1; end
                        else if (m_single || m_want_stop) m_busy = 0;
                        m_want_stop = 0; m_want_halt = 0;
                    end
                    m_pos = (m_pos + 1) % 4;
                end
            end
        end
    endtask

    task automatic model_check(string tag);
        bit [3:0]    got_ph, exp_ph;
        logic [31:0] exp_cnt;
        got_ph = {PHASE_FT, PHASE_DC, PHASE_EX, PHASE_WB};
        exp_ph = (m_busy && !STALL) ? (4'b1000 >> m_pos) : 4'b0000;
`ifdef CPU_PHASE_INSTR_CNT_EN
        exp_cnt = m_retired;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (got_ph !== exp_ph || RUNNING !== m_busy || HALTED !== m_halted || INSTR_CNT !== exp_cnt) begin
            errors++;
            $display("FAIL %s model: got ph=%b run=%b halt=%b cnt=%0d, expected ph=%b run=%b halt=%b cnt=%0d",
                     tag, got_ph, RUNNING, HALTED, INSTR_CNT, exp_ph, m_busy, m_halted, exp_cnt);
        end
        checks++;
        if ($countones(got_ph) > 1) begin
            errors++;
            $display("FAIL %s onehot: got ph=%b, required at most one bit", tag, got_ph);
        end
    endtask

    task automatic tick(input vec_t v, input string tag);
        RST = v.rst; START = v.start; STOP = v.stop; STEP = v.step;
        HALT_REQ = v.halt_req; STALL = v.stall;
        #2;
        if (v.chk) begin
            checks++;
            if ({PHASE_FT, PHASE_DC, PHASE_EX, PHASE_WB} !== v.ph || RUNNING !== v.run || HALTED !== v.hal) begin
                errors++;
                $display("FAIL %s table: got ph=%b run=%b halt=%b, expected ph=%b run=%b halt=%b",
                         tag, {PHASE_FT, PHASE_DC, PHASE_EX, PHASE_WB}, RUNNING, HALTED, v.ph, v.run, v.hal);
            end
        end
        if (m_valid) model_check(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    initial begin
        vec_t v;
        RST = 0; START = 0; STOP = 0; STEP = 0; HALT_REQ = 0; STALL = 0;

        // Reset, START, three free-running instructions plus the FT of a fourth.
        add(0, 1,0,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,0,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,1,0,0,0,0, 4'b0000, 0, 0);
        for (int i = 0; i < 13; i++) add(1, 0,0,0,0,0,0, 4'b1000 >> (i % 4), 1, 0);
        // STOP during DC: EX, WB still issue, then idle with no FT.
        add(1, 0,0,1,0,0,0, 4'b0100, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0010, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0001, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,0,0,0,0,0, 4'b0000, 0, 0);
        // Two single steps.
        for (int s = 0; s < 2; s++) begin
            add(1, 0,0,0,1,0,0, 4'b0000, 0, 0);
            for (int i = 0; i < 4; i++) add(1, 0,0,0,0,0,0, 4'b1000 >> i, 1, 0);
            add(1, 0,0,0,0,0,0, 4'b0000, 0, 0);
        end
        // HALT_REQ with STOP in EX: WB, HALTED, STEP ignored, START resumes at FT.
        add(1, 0,1,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,0,0,0,0,0, 4'b1000, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0100, 1, 0);
        add(1, 0,0,1,0,1,0, 4'b0010, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0001, 1, 0);
        add(1, 0,0,0,1,0,0, 4'b0000, 0, 1);
        add(1, 0,0,1,0,0,0, 4'b0000, 0, 1);
        add(1, 0,1,0,0,0,0, 4'b0000, 0, 1);
        add(1, 0,0,0,0,0,0, 4'b1000, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0100, 1, 0);
        // STALL for 5 cycles from the EX slot.
        for (int i = 0; i < 5; i++) add(1, 0,0,0,0,0,1, 4'b0000, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0010, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0001, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b1000, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0100, 1, 0);
        // Reset during EX aborts the instruction; START restarts at FT.
        add(1, 1,0,0,0,0,0, 4'b0010, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,1,0,0,0,0, 4'b0000, 0, 0);
        add(1, 0,0,0,0,0,0, 4'b1000, 1, 0);
        add(1, 0,0,0,0,0,0, 4'b0100, 1, 0);

        @(posedge CLK);
        #1;
        foreach (vecs[i]) tick(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 4000; i++) begin
            v.chk      = 0;
            v.rst      = ($urandom_range(0, 299) == 0);
            v.start    = ($urandom_range(0, 7) == 0);
            v.stop     = ($urandom_range(0, 11) == 0);
            v.step     = ($urandom_range(0, 7) == 0);
            v.halt_req = ($urandom_range(0, 5) == 0);
            v.stall    = ($urandom_range(0, 3) == 0);
            v.ph = 4'b0000; v.run = 0; v.hal = 0;
            tick(v, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
